// File: rtl/spi_adc_responder_if.sv
// Link bundle between the ADC serial master and the responder: frame control, serial lines,
// the per-conversion inputs, and the responder's receive and status outputs.
interface spi_adc_responder_if #(
  parameter int MAX_BITS = 24
);
  logic                CONV;
  logic                SCK;
  logic                SDI;
  logic                SDO;
  logic [4:0]          ndb;
  logic [MAX_BITS-1:0] adc_sample;
  logic [MAX_BITS-1:0] rx_data;
  logic                rx_valid;
  logic                short_frame;
  logic                busy;

  modport master (
    output CONV, SCK, SDI, ndb, adc_sample,
    input  SDO, rx_data, rx_valid, short_frame, busy
  );

  modport slave (
    input  CONV, SCK, SDI, ndb, adc_sample,
    output SDO, rx_data, rx_valid, short_frame, busy
  );
endinterface

// File: rtl/spi_adc_responder.sv
// ADC emulator on the CONV/SCK/SDI/SDO link: latches a sample at CONV rise and shifts it out MSB-first.
// It also captures the master's SDI word. Link inputs are sampled on S_AXI_ACLK and are never used as clocks.
module spi_adc_responder #(
  parameter int MAX_BITS = 24
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESET,
  spi_adc_responder_if.slave    link
);

  typedef enum logic [1:0] {IDLE, CONVERT, SHIFT, DONE} state_e;

  localparam logic [4:0] MAXB = 5'(MAX_BITS);

  state_e              state_q, state_d;
  logic                conv_q, sck_q;
  logic [4:0]          ndb_l_q, ndb_l_d;
  logic [4:0]          bitcnt_q, bitcnt_d;
  logic [MAX_BITS-1:0] hold_q, hold_d;
  logic [MAX_BITS-1:0] tx_sr_q, tx_sr_d;
  logic [MAX_BITS-1:0] rx_sr_q, rx_sr_d;
  logic [MAX_BITS-1:0] rx_data_q, rx_data_d;
  logic                sdo_q, sdo_d;
  logic                rx_valid_q, rx_valid_d;
  logic                short_q, short_d;
  logic                busy_q, busy_d;

  logic                conv_rise, conv_fall, sck_rise, sck_fall;
  logic [4:0]          ndb_clamped;
  logic [MAX_BITS-1:0] rx_shifted;

  assign conv_rise   = link.CONV & ~conv_q;
  assign conv_fall   = ~link.CONV & conv_q;
  assign sck_rise    = link.SCK & ~sck_q;
  assign sck_fall    = ~link.SCK & sck_q;
  assign ndb_clamped = (link.ndb > MAXB) ? MAXB : link.ndb;
  assign rx_shifted  = {rx_sr_q[MAX_BITS-2:0], link.SDI};

  always_comb begin
    state_d    = state_q;
    ndb_l_d    = ndb_l_q;
    bitcnt_d   = bitcnt_q;
    hold_d     = hold_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    short_d    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (conv_rise) begin
          state_d  = CONVERT;
          ndb_l_d  = ndb_clamped;
          hold_d   = link.adc_sample;
          bitcnt_d = 5'd0;
        end
      end
      CONVERT: begin
        if (conv_fall) begin
          state_d = (ndb_l_q != 5'd0) ? SHIFT : DONE;
          // Left-justify so the frame's MSB sits at the top of the shifter.
          tx_sr_d = hold_q << (MAXB - ndb_l_q);
        end
      end
      SHIFT: begin
        // A new conversion overrides any SCK edge in the same cycle.
        if (conv_rise) begin
          state_d  = CONVERT;
          short_d  = (bitcnt_q < ndb_l_q);
          ndb_l_d  = ndb_clamped;
          hold_d   = link.adc_sample;
          bitcnt_d = 5'd0;
        end else if (sck_rise) begin
          rx_sr_d  = rx_shifted;
          bitcnt_d = bitcnt_q + 5'd1;
          if (bitcnt_d == ndb_l_q) begin
            rx_data_d  = rx_shifted & ({MAX_BITS{1'b1}} >> (MAXB - ndb_l_q));
            rx_valid_d = 1'b1;
          end
        end else if (sck_fall) begin
          tx_sr_d = tx_sr_q << 1;
          if (bitcnt_q == ndb_l_q) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    sdo_d  = (state_d == SHIFT) ? tx_sr_d[MAX_BITS-1] : 1'b0;
    busy_d = (state_d == CONVERT) || (state_d == SHIFT);
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q    <= IDLE;
      conv_q     <= 1'b0;
      sck_q      <= 1'b0;
      ndb_l_q    <= 5'd0;
      bitcnt_q   <= 5'd0;
      hold_q     <= '0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      sdo_q      <= 1'b0;
      rx_valid_q <= 1'b0;
      short_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      conv_q     <= link.CONV;
      sck_q      <= link.SCK;
      ndb_l_q    <= ndb_l_d;
      bitcnt_q   <= bitcnt_d;
      hold_q     <= hold_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      sdo_q      <= sdo_d;
      rx_valid_q <= rx_valid_d;
      short_q    <= short_d;
      busy_q     <= busy_d;
    end
  end

  assign link.SDO         = sdo_q;
  assign link.rx_data     = rx_data_q;
  assign link.rx_valid    = rx_valid_q;
  assign link.short_frame = short_q;
  assign link.busy        = busy_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Bench for spi_adc_responder: acts as the serial master and compares the link against a word-level
// model (the sample and the SDI word, each masked to the clamped frame length).
module tb_spi_adc_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  int           rv_cnt = 0;
  int           sf_cnt = 0;
  logic [23:0]  last_rx = '0;

  spi_adc_responder_if #(.MAX_BITS(24)) bus ();

  spi_adc_responder #(.MAX_BITS(24)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .link         (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.rx_valid === 1'b1) begin
      rv_cnt++;
      last_rx = bus.rx_data;
    end
    if (bus.short_frame === 1'b1) sf_cnt++;
  end

  function automatic logic [23:0] lowmask(input int n);
    logic [24:0] m;
    m = (25'd1 << n) - 25'd1;
    return m[23:0];
  endfunction

  function automatic int eff_bits(input int nb);
    return (nb > 24) ? 24 : nb;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Master frame: CONV high (optionally toggling SCK meanwhile), then up to stop_after bits with
  // SCK 3 cycles high / 3 low. SDO is sampled two cycles into each high phase.
  task automatic run_frame(input int nb, input logic [23:0] samp, input logic [23:0] sdi_w,
                           input int stop_after, input int pre_toggles, output logic [23:0] got);
    int eff;
    int n;
    eff = eff_bits(nb);
    n   = (stop_after < eff) ? stop_after : eff;
    got = '0;
    tick();
    bus.CONV = 1'b1;
    bus.ndb = 5'(nb);
    bus.adc_sample = samp;
    tick();
    bus.adc_sample = 24'($urandom);
    bus.ndb = 5'($urandom);
    for (int k = 0; k < pre_toggles; k++) begin
      bus.SCK = 1'b1;
      tick();
      bus.SCK = 1'b0;
      tick();
    end
    repeat (2) tick();
    bus.CONV = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < n; i++) begin
      bus.SDI = sdi_w[eff-1-i];
      bus.SCK = 1'b1;
      repeat (2) tick();
      got[eff-1-i] = bus.SDO;
      tick();
      bus.SCK = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic test_reset();
    total++; if (bus.SDO !== 1'b0) begin bad++; $display("FAIL reset_sdo got=%b want=0", bus.SDO); end
    total++; if (bus.rx_data !== 24'h0) begin bad++; $display("FAIL reset_rx_data got=%h want=0", bus.rx_data); end
    total++; if (bus.rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", bus.rx_valid); end
    total++; if (bus.short_frame !== 1'b0) begin bad++; $display("FAIL reset_short got=%b want=0", bus.short_frame); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_frame16();
    logic [23:0] got;
    int rv0, sf0;
    rv0 = rv_cnt; sf0 = sf_cnt;
    run_frame(16, 24'h00A5C3, 24'h001234, 99, 0, got);
    total++; if (got !== 24'h00A5C3) begin bad++; $display("FAIL f16_sdo got=%h want=00a5c3", got); end
    total++; if (last_rx !== 24'h001234) begin bad++; $display("FAIL f16_rx got=%h want=001234", last_rx); end
    total++; if (rv_cnt - rv0 !== 1) begin bad++; $display("FAIL f16_rv_count got=%0d want=1", rv_cnt - rv0); end
    total++; if (sf_cnt !== sf0) begin bad++; $display("FAIL f16_short got=%0d want=%0d", sf_cnt, sf0); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL f16_busy_done got=%b want=0", bus.busy); end
  endtask

  task automatic test_ndb24();
    logic [23:0] got;
    logic [23:0] sdi_w;
    sdi_w = 24'($urandom);
    run_frame(24, 24'hFFFFFF, sdi_w, 99, 0, got);
    total++; if (got !== 24'hFFFFFF) begin bad++; $display("FAIL n24_ones got=%h want=ffffff", got); end
    total++; if (last_rx !== sdi_w) begin bad++; $display("FAIL n24_rx got=%h want=%h", last_rx, sdi_w); end
    sdi_w = 24'($urandom);
    run_frame(24, 24'h000001, sdi_w, 99, 0, got);
    total++; if (got !== 24'h000001) begin bad++; $display("FAIL n24_one got=%h want=000001", got); end
    total++; if (bus.SDO !== 1'b0) begin bad++; $display("FAIL n24_sdo_done got=%b want=0", bus.SDO); end
  endtask

  task automatic test_short_frame();
    logic [23:0] got;
    logic [23:0] samp;
    logic [23:0] sdi_w;
    int rv0, sf0;
    rv0 = rv_cnt; sf0 = sf_cnt;
    run_frame(12, 24'($urandom), 24'($urandom), 5, 0, got);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL short_busy_mid got=%b want=1", bus.busy); end
    samp = 24'($urandom); sdi_w = 24'($urandom);
    run_frame(12, samp, sdi_w, 99, 0, got);
    total++; if (sf_cnt - sf0 !== 1) begin bad++; $display("FAIL short_pulse got=%0d want=1", sf_cnt - sf0); end
    total++; if (rv_cnt - rv0 !== 1) begin bad++; $display("FAIL short_rv got=%0d want=1", rv_cnt - rv0); end
    total++; if (got !== (samp & lowmask(12))) begin bad++; $display("FAIL short_next_sdo got=%h want=%h", got, samp & lowmask(12)); end
    total++; if (last_rx !== (sdi_w & lowmask(12))) begin bad++; $display("FAIL short_next_rx got=%h want=%h", last_rx, sdi_w & lowmask(12)); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] got;
    int rv0, sf0;
    rv0 = rv_cnt; sf0 = sf_cnt;
    run_frame(16, 24'hFFFF, 24'hFFFF, 8, 0, got);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rmid_busy_before got=%b want=1", bus.busy); end
    bus.SCK = 1'b1;
    rst = 1'b1;
    tick();
    total++; if (bus.SDO !== 1'b0) begin bad++; $display("FAIL rmid_sdo got=%b want=0", bus.SDO); end
    total++; if (bus.rx_data !== 24'h0) begin bad++; $display("FAIL rmid_rx_data got=%h want=0", bus.rx_data); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", bus.busy); end
    rst = 1'b0;
    bus.SCK = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(); bus.SCK = 1'b1; tick(); bus.SCK = 1'b0;
    end
    repeat (2) tick();
    total++; if (rv_cnt !== rv0 || sf_cnt !== sf0) begin bad++; $display("FAIL rmid_pulses got=%0d/%0d want=%0d/%0d", rv_cnt, sf_cnt, rv0, sf0); end
    total++; if (bus.busy !== 1'b0 || bus.SDO !== 1'b0) begin bad++; $display("FAIL rmid_idle_sck busy=%b sdo=%b want=0/0", bus.busy, bus.SDO); end
  endtask

  task automatic test_ndb0();
    logic [23:0] got;
    logic [23:0] samp;
    logic [23:0] sdi_w;
    int rv0, sf0;
    rv0 = rv_cnt; sf0 = sf_cnt;
    run_frame(0, 24'hFFFFFF, 24'hFFFFFF, 99, 3, got);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL n0_busy got=%b want=0", bus.busy); end
    for (int k = 0; k < 3; k++) begin
      bus.SCK = 1'b1; bus.SDI = 1'b1;
      repeat (2) tick();
      total++; if (bus.SDO !== 1'b0) begin bad++; $display("FAIL n0_sdo got=%b want=0", bus.SDO); end
      bus.SCK = 1'b0;
      repeat (2) tick();
    end
    total++; if (rv_cnt !== rv0 || sf_cnt !== sf0) begin bad++; $display("FAIL n0_pulses got=%0d/%0d want=%0d/%0d", rv_cnt, sf_cnt, rv0, sf0); end
    samp = 24'($urandom); sdi_w = 24'($urandom);
    run_frame(8, samp, sdi_w, 99, 4, got);
    total++; if (got !== (samp & lowmask(8))) begin bad++; $display("FAIL conv_sck_sdo got=%h want=%h", got, samp & lowmask(8)); end
    total++; if (last_rx !== (sdi_w & lowmask(8))) begin bad++; $display("FAIL conv_sck_rx got=%h want=%h", last_rx, sdi_w & lowmask(8)); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] got;
    logic [23:0] samp;
    logic [23:0] sdi_w;
    int nb, eff, rv0, sf0;
    for (int f = 0; f < 16; f++) begin
      if (f == 0)      begin nb = 8; samp = 24'h00003C; end
      else if (f == 1) begin nb = 8; samp = 24'h0000C3; end
      else begin
        nb = (f % 5 == 0) ? int'($urandom_range(25, 31)) : int'($urandom_range(1, 24));
        samp = 24'($urandom);
      end
      eff = eff_bits(nb);
      sdi_w = 24'($urandom);
      rv0 = rv_cnt; sf0 = sf_cnt;
      run_frame(nb, samp, sdi_w, 99, 0, got);
      total++; if (got !== (samp & lowmask(eff))) begin bad++; $display("FAIL b2b_sdo frame=%0d ndb=%0d got=%h want=%h", f, nb, got, samp & lowmask(eff)); end
      total++; if (rv_cnt - rv0 !== 1 || last_rx !== (sdi_w & lowmask(eff))) begin bad++; $display("FAIL b2b_rx frame=%0d pulses=%0d got=%h want=%h", f, rv_cnt - rv0, last_rx, sdi_w & lowmask(eff)); end
      total++; if (sf_cnt !== sf0) begin bad++; $display("FAIL b2b_short frame=%0d got=%0d want=%0d", f, sf_cnt - sf0, 0); end
    end
  endtask

  initial begin
    bus.CONV = 1'b0;
    bus.SCK = 1'b0;
    bus.SDI = 1'b0;
    bus.ndb = 5'd0;
    bus.adc_sample = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    test_reset();
    test_frame16();
    test_ndb24();
    test_short_frame();
    test_reset_mid();
    test_ndb0();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
